stream_arbiter: RTL and testbench

STREAM_ARBITER -- requirements
Module: stream_arbiter

---
 rtl/stream_arb_pkg.sv | 18 +
 rtl/rr_pick.sv | 40 ++++
 rtl/stream_arbiter.sv | 134 +++++++++++++
 tb/tb_stream_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and default constants for the stream arbiter.
package stream_arb_pkg;

    localparam int unsigned DefaultN  = 4;
    localparam int unsigned DefaultDw = 8;
    localparam int unsigned DefaultCw = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Index width for an n-entry vector; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first request at or after i_ptr, wrapping.
module rr_pick
    import stream_arb_pkg::*;
#(
    parameter  int unsigned N   = DefaultN,
    localparam int unsigned IW  = idx_width(N),
    localparam int unsigned IW1 = IW + 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo N and keep the first requester
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_found  = 1'b0;
        w_sum    = '0;
        w_cand   = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_sum = {1'b0, i_ptr} + IW1'(k);
            if (w_sum >= IW1'(N)) begin
                w_sum = w_sum - IW1'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!o_found && i_req[w_cand]) begin
                o_found          = 1'b1;
                o_idx            = w_cand;
                o_onehot[w_cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// Packet-locked round-robin stream arbiter merging N sources into one stream.
// Optional per-source completed-packet counters: define STREAM_ARB_STATS_EN.
module stream_arbiter
    import stream_arb_pkg::*;
#(
    parameter int unsigned N  = DefaultN,
    parameter int unsigned DW = DefaultDw,
    parameter int unsigned CW = DefaultCw
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N*DW-1:0] s_data,
    input  logic [N-1:0]    s_valid,
    input  logic [N-1:0]    s_last,
    output logic [N-1:0]    s_ready,
    output logic [DW-1:0]   m_data,
    output logic            m_valid,
    output logic            m_last,
    input  logic            m_ready,
    output logic [N-1:0]    grant,
    output logic            busy
`ifdef STREAM_ARB_STATS_EN
    ,
    output logic [N*CW-1:0] pkt_count
`endif
);

    localparam int unsigned IW = idx_width(N);

    if (N < 2 || N > 16 || DW < 1 || CW < 1) begin : g_param_check
        $error("stream_arbiter: unsupported parameter values");
    end

    arb_state_e    r_state, w_state_next;
    logic [IW-1:0] r_ptr, w_ptr_next;
    logic [IW-1:0] r_sel, w_sel_next;
    logic [N-1:0]  r_grant, w_grant_next;

    logic [N-1:0]  w_pick_onehot;
    logic [IW-1:0] w_pick_idx;
    logic          w_pick_found;
    logic          w_xfer;
    logic          w_done;

    rr_pick #(
        .N (N)
    ) u_rr_pick (
        .i_req    (s_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_found  (w_pick_found)
    );

    assign grant = r_grant;

    // Arbitration state, owner and round-robin pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_grant <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_sel   <= w_sel_next;
            r_grant <= w_grant_next;
        end
    end

    // Next-state decode and pass-through of the owning source
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_sel_next   = r_sel;
        w_grant_next = r_grant;
        m_data       = '0;
        m_valid      = 1'b0;
        m_last       = 1'b0;
        s_ready      = '0;
        busy         = 1'b0;
        w_xfer       = 1'b0;
        w_done       = 1'b0;
        unique case (r_state)
            IDLE: begin
                // Winner is latched here, so a later drop of its valid keeps the grant
                if (w_pick_found) begin
                    w_state_next = GRANT;
                    w_sel_next   = w_pick_idx;
                    w_grant_next = w_pick_onehot;
                end
            end
            GRANT: begin
                busy    = 1'b1;
                m_data  = s_data[int'(r_sel) * int'(DW) +: DW];
                m_valid = s_valid[r_sel];
                m_last  = s_last[r_sel];
                s_ready = r_grant & {N{m_ready}};
                w_xfer  = m_valid & m_ready;
                w_done  = w_xfer & m_last;
                // Only a transferred last beat releases the lock
                if (w_done) begin
                    w_state_next = IDLE;
                    w_grant_next = '0;
                    w_ptr_next   = (r_sel == IW'(N - 1)) ? '0 : r_sel + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef STREAM_ARB_STATS_EN
    logic [CW-1:0] r_pkt_cnt [N];

    // Completed-packet counters; wrap naturally at 2^CW
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N); i++) begin
                r_pkt_cnt[i] <= '0;
            end
        end else if (w_done) begin
            r_pkt_cnt[r_sel] <= r_pkt_cnt[r_sel] + 1'b1;
        end
    end

    for (genvar g = 0; g < int'(N); g++) begin : g_pkt_count
        assign pkt_count[g*CW +: CW] = r_pkt_cnt[g];
    end
`endif

endmodule

// File: tb/tb_stream_arbiter.sv
// Bench for stream_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N*DW-1:0] s_data = '0;
    logic [N-1:0]    s_valid = '0;
    logic [N-1:0]    s_last = '0;
    logic [N-1:0]    s_ready;
    logic [DW-1:0]   m_data;
    logic            m_valid;
    logic            m_last;
    logic            m_ready = 1'b1;
    logic [N-1:0]    grant;
    logic            busy;
`ifdef STREAM_ARB_STATS_EN
    logic [N*CW-1:0] pkt_count;
`endif

    stream_arbiter #(
        .N  (N),
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .grant     (grant),
        .busy      (busy)
`ifdef STREAM_ARB_STATS_EN
        ,
        .pkt_count (pkt_count)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model: owner (-1 when idle), round-robin pointer, packet counts
    int mdl_owner = -1;
    int mdl_ptr   = 0;
    int mdl_cnt [N];

    // Directed source generators
    int src_pkts [N];
    int src_len  [N];
    int src_beat [N];
    int src_seq  [N];
    bit src_hold [N];
    bit rand_mode    = 1'b0;
    bit toggle_ready = 1'b0;

    logic [N-1:0]  hist[$];
    logic [DW-1:0] xfer_log[$];
    logic [N-1:0]  exp_g[$];
    logic [DW-1:0] exp_d[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                s_valid[i] = ($urandom_range(0, 3) != 0);
                s_last[i]  = ($urandom_range(0, 3) == 0);
            end
            s_data  = 32'($urandom);
            m_ready = ($urandom_range(0, 3) != 0);
        end else begin
            for (int i = 0; i < N; i++) begin
                s_valid[i]         = (src_pkts[i] > 0) && !src_hold[i];
                s_last[i]          = (src_beat[i] == src_len[i] - 1);
                s_data[i*DW +: DW] = 8'((i << 6) | (src_seq[i] & 63));
            end
            if (toggle_ready) m_ready = ~m_ready;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] eg;
        bit           own;
        own = (mdl_owner >= 0);
        eg  = own ? 4'(1 << mdl_owner) : 4'b0000;
        chk("grant", 32'(grant), 32'(eg));
        chk("busy", 32'(busy), 32'(own));
        chk("s_ready", 32'(s_ready), 32'(m_ready ? eg : 4'b0000));
        chk("m_valid", 32'(m_valid), 32'(own && s_valid[mdl_owner]));
        chk("m_last", 32'(m_last), 32'(own && s_last[mdl_owner]));
        if (own && s_valid[mdl_owner]) begin
            chk("m_data", 32'(m_data), 32'(s_data[mdl_owner*DW +: DW]));
        end
`ifdef STREAM_ARB_STATS_EN
        for (int i = 0; i < N; i++) begin
            chk("pkt_count", 32'(pkt_count[i*CW +: CW]), 32'(mdl_cnt[i]));
        end
`endif
    endtask

    // Advance the model across the coming rising edge
    task automatic model_step();
        int prev;
        int j;
        prev = mdl_owner;
        if (m_valid === 1'b1 && m_ready) xfer_log.push_back(m_data);
        if (prev >= 0) begin
            if (s_valid[prev] && m_ready && s_last[prev]) begin
                mdl_cnt[prev] = (mdl_cnt[prev] + 1) % (1 << CW);
                mdl_ptr       = (prev + 1) % N;
                mdl_owner     = -1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (mdl_ptr + k) % N;
                if (mdl_owner < 0 && s_valid[j]) mdl_owner = j;
            end
        end
        if (!rand_mode && prev >= 0 && s_valid[prev] && m_ready) begin
            src_seq[prev]++;
            src_beat[prev]++;
            if (src_beat[prev] == src_len[prev]) begin
                src_beat[prev] = 0;
                src_pkts[prev]--;
            end
        end
    endtask

    task automatic cycle();
        drive();
        #4;
        check_outputs();
        if (grant !== hist[$]) hist.push_back(grant);
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_until_done(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            done = (mdl_owner < 0);
            for (int i = 0; i < N; i++) if (src_pkts[i] > 0) done = 1'b0;
            if (!done) cycle();
        end
        chk("run_budget", 32'(done), 32'd1);
        cycle();
    endtask

    task automatic expect_grants(input string tag);
        chk(tag, 32'(hist.size()), 32'(exp_g.size()));
        foreach (exp_g[i]) if (i < hist.size()) chk(tag, 32'(hist[i]), 32'(exp_g[i]));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mdl_owner = -1;
        mdl_ptr   = 0;
        for (int i = 0; i < N; i++) begin
            mdl_cnt[i]  = 0;
            src_pkts[i] = 0;
            src_len[i]  = 0;
            src_beat[i] = 0;
            src_hold[i] = 1'b0;
        end
        rand_mode    = 1'b0;
        toggle_ready = 1'b0;
        m_ready      = 1'b1;
        drive();
        #1;
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        hist.delete();
        hist.push_back(4'b0000);
        xfer_log.delete();
    endtask

    initial begin
        for (int i = 0; i < N; i++) src_seq[i] = 0;

        // Two sources, 3-beat packets
        do_reset();
        src_pkts[0] = 1; src_len[0] = 3;
        src_pkts[2] = 1; src_len[2] = 3;
        run_until_done(60);
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        expect_grants("two_src_order");

        // All four sources continuously valid, 2-beat packets
        do_reset();
        for (int i = 0; i < N; i++) begin
            src_pkts[i] = 1;
            src_len[i]  = 2;
        end
        src_pkts[0] = 2;
        run_until_done(100);
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000,
                  4'b1000, 4'b0000, 4'b0001, 4'b0000};
        expect_grants("rr_order");

        // Toggling m_ready: every beat delivered exactly once, in order
        do_reset();
        src_seq[1] = 0;
        src_pkts[1] = 1; src_len[1] = 4;
        toggle_ready = 1'b1;
        run_until_done(60);
        toggle_ready = 1'b0;
        exp_d = '{8'h40, 8'h41, 8'h42, 8'h43};
        chk("beat_count", 32'(xfer_log.size()), 32'(exp_d.size()));
        foreach (exp_d[i]) if (i < xfer_log.size()) chk("beat_data", 32'(xfer_log[i]), 32'(exp_d[i]));

        // Owner stalls mid-packet while source 3 waits
        do_reset();
        src_pkts[0] = 1; src_len[0] = 4;
        cycle(); cycle(); cycle();
        src_hold[0] = 1'b1;
        src_pkts[3] = 1; src_len[3] = 1;
        for (int c = 0; c < 5; c++) begin
            cycle();
            chk("hold_grant", 32'(grant), 32'(4'b0001));
            chk("hold_m_valid", 32'(m_valid), 32'd0);
            chk("hold_src3_ready", 32'(s_ready[3]), 32'd0);
        end
        src_hold[0] = 1'b0;
        run_until_done(60);
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
        expect_grants("hold_order");

        // Asynchronous reset mid-packet, then arbitration restarts at source 0
        do_reset();
        src_pkts[2] = 1; src_len[2] = 4;
        cycle(); cycle(); cycle();
        chk("pre_rst_grant", 32'(grant), 32'(4'b0100));
        drive();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_grant", 32'(grant), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_s_ready", 32'(s_ready), 32'd0);
        chk("async_m_valid", 32'(m_valid), 32'd0);
        chk("async_m_last", 32'(m_last), 32'd0);
        do_reset();
        src_pkts[0] = 1; src_len[0] = 1;
        src_pkts[2] = 1; src_len[2] = 1;
        run_until_done(60);
        exp_g = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
        expect_grants("post_rst_order");

`ifdef STREAM_ARB_STATS_EN
        // Five packets from source 1 wrap a 2-bit counter to 1
        do_reset();
        src_pkts[1] = 5; src_len[1] = 2;
        run_until_done(100);
        chk("pkt_count_wrap", 32'(pkt_count), 32'h04);
`endif

        // Randomized traffic against the model
        do_reset();
        rand_mode = 1'b1;
        for (int c = 0; c < 600; c++) cycle();
        rand_mode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
